// File: rtl/divf_seq_pkg.sv
// Shared fp32 definitions for the sequential divider: field widths, bias,
// canonical constants, FSM encoding and iteration count.
package divf_seq_pkg;

    localparam int unsigned SIGN_W = 1;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned MANT_W = FRAC_W + 1;   // with hidden 1
    localparam int unsigned QUO_W  = 25;           // one integer + 24 fraction bits
    localparam int unsigned EXPI_W = 10;           // signed working exponent
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned ITERS  = 25;
    localparam int unsigned BIAS   = 127;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_INF  = 32'h7F80_0000;

    typedef struct packed {
        logic [SIGN_W-1:0] sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/divf_mant.sv
// Restoring mantissa divider, one quotient bit per step.
//   load     : capture dividend/divisor (both with hidden 1), clear quotient
//   step     : produce next quotient bit (MSB first)
//   quo      : accumulated quotient; after 25 steps quo = floor(dividend/divisor * 2^24)
module divf_mant
    import divf_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [MANT_W-1:0] dividend,
    input  logic [MANT_W-1:0] divisor,
    output logic [QUO_W-1:0]  quo
);

    logic [MANT_W:0]   rem_q,  rem_d;
    logic [MANT_W-1:0] dvs_q,  dvs_d;
    logic [QUO_W-1:0]  quo_q,  quo_d;
    logic              ge;
    logic [MANT_W:0]   diff;

    // Remainder stays below 2*divisor, so MANT_W+1 bits hold it.
    always_comb begin
        rem_d = rem_q;
        dvs_d = dvs_q;
        quo_d = quo_q;
        ge    = (rem_q >= {1'b0, dvs_q});
        diff  = ge ? (rem_q - {1'b0, dvs_q}) : rem_q;
        if (load) begin
            rem_d = {1'b0, dividend};
            dvs_d = divisor;
            quo_d = '0;
        end else if (step) begin
            // diff < divisor < 2^MANT_W, so its top bit is always zero
            rem_d = {diff[MANT_W-1:0], 1'b0};
            quo_d = {quo_q[QUO_W-2:0], ge};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            dvs_q <= '0;
            quo_q <= '0;
        end else begin
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            quo_q <= quo_d;
        end
    end

    assign quo = quo_q;

endmodule

// File: rtl/divf_seq.sv
// Sequential IEEE-754 single-precision divider (round toward zero, no denormals).
//   clk, rst_n : clock, async active-low reset
//   start,a,b  : request and operands, sampled in IDLE only
//   busy       : operation in flight (accept edge through end of done)
//   done       : one-cycle result pulse
//   q, dz      : quotient and divide-by-zero flag, held until the next result
module divf_seq
    import divf_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] q,
    output logic        dz
);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [EXPI_W-1:0]  exp_q, exp_d;
    logic                      sign_q, sign_d;
    logic                      spec_q, spec_d;
    logic [31:0]               spec_res_q, spec_res_d;
    logic                      spec_dz_q, spec_dz_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [31:0]               q_q, q_d;
    logic                      dz_q, dz_d;

    fp32_t                     fa, fb;
    logic                      a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic                      sign_c;
    logic                      is_spec_c;
    logic [31:0]               spec_val_c;
    logic                      spec_dz_c;
    logic                      mant_load, mant_step;
    logic [QUO_W-1:0]          quo;
    logic signed [EXPI_W-1:0]  exp_n;
    logic [FRAC_W-1:0]         frac_n;

    assign fa     = a;
    assign fb     = b;
    assign sign_c = fa.sign ^ fb.sign;
    assign a_zero = ~|fa.exp;
    assign b_zero = ~|fb.exp;
    assign a_inf  = (&fa.exp) & ~|fa.frac;
    assign b_inf  = (&fb.exp) & ~|fb.frac;
    assign a_nan  = (&fa.exp) & |fa.frac;
    assign b_nan  = (&fb.exp) & |fb.frac;

    // Special-operand decode; priority order matters (NaN cases first).
    always_comb begin
        is_spec_c  = 1'b1;
        spec_val_c = FP_QNAN;
        spec_dz_c  = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_val_c = FP_QNAN;
        end else if (a_inf) begin
            spec_val_c = FP_INF | {sign_c, 31'd0};
        end else if (b_inf || a_zero) begin
            spec_val_c = {sign_c, 31'd0};
        end else if (b_zero) begin
            spec_val_c = FP_INF | {sign_c, 31'd0};
            spec_dz_c  = 1'b1;
        end else begin
            is_spec_c  = 1'b0;
        end
    end

    // Normalise: quotient lies in [0.5, 2); a clear integer bit needs one left shift.
    always_comb begin
        exp_n  = quo[QUO_W-1] ? exp_q : (exp_q - 10'sd1);
        frac_n = quo[QUO_W-1] ? quo[QUO_W-2:1] : quo[QUO_W-3:0];
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        spec_dz_d  = spec_dz_q;
        done_d     = 1'b0;
        q_d        = q_q;
        dz_d       = dz_q;
        mant_load  = 1'b0;
        mant_step  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sign_d = sign_c;
                    exp_d  = $signed({2'b00, fa.exp}) - $signed({2'b00, fb.exp})
                             + $signed(EXPI_W'(BIAS));
                    if (is_spec_c) begin
                        spec_d     = 1'b1;
                        spec_res_d = spec_val_c;
                        spec_dz_d  = spec_dz_c;
                        state_d    = ST_DONE;
                    end else begin
                        cnt_d      = '0;
                        mant_load  = 1'b1;
                        state_d    = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                mant_step = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (exp_n >= 10'sd255) begin
                    q_d = FP_INF | {sign_q, 31'd0};
                end else if (exp_n <= 10'sd0) begin
                    q_d = {sign_q, 31'd0};
                end else begin
                    q_d = {sign_q, exp_n[EXP_W-1:0], frac_n};
                end
                dz_d    = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // Special results spend one settle cycle here, then publish with done.
                if (spec_q) begin
                    q_d    = spec_res_q;
                    dz_d   = spec_dz_q;
                    done_d = 1'b1;
                    spec_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            spec_dz_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            q_q        <= '0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            spec_dz_q  <= spec_dz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            q_q        <= q_d;
            dz_q       <= dz_d;
        end
    end

    divf_mant u_mant (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (mant_load),
        .step     (mant_step),
        .dividend ({1'b1, fa.frac}),
        .divisor  ({1'b1, fb.frac}),
        .quo      (quo)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_divf_seq.sv
// Self-checking bench for divf_seq: directed vectors plus randomized operands
// checked against an arithmetic reference model of fp32 truncating division.
module tb_divf_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done, dz;
    logic [31:0] q;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    divf_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .dz    (dz)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Reference: {special, dz, q}. Quotient = floor(ma/mb * 2^24), truncated to 23 bits.
    function automatic logic [33:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        int          ex, ey, e;
        logic [22:0] fx, fy;
        logic [63:0] mx, my, quot;
        logic [22:0] frac;
        bit          xz, yz, xi, yi, xn, yn;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);  ey = int'(y[30:23]);
        fx = x[22:0];         fy = y[22:0];
        xz = (ex == 0);       yz = (ey == 0);
        xi = (ex == 255) && (fx == 0);  yi = (ey == 255) && (fy == 0);
        xn = (ex == 255) && (fx != 0);  yn = (ey == 255) && (fy != 0);
        if (xn || yn || (xz && yz) || (xi && yi)) return {2'b10, 32'h7FC00000};
        if (xi)        return {2'b10, s, 31'h7F800000};
        if (yi || xz)  return {2'b10, s, 31'h0};
        if (yz)        return {2'b11, s, 31'h7F800000};
        mx   = 64'(fx) + 64'h800000;
        my   = 64'(fy) + 64'h800000;
        quot = (mx << 24) / my;
        e    = ex - ey + 127;
        if (quot >= 64'h1000000) begin
            frac = 23'((quot >> 1) & 64'h7FFFFF);
        end else begin
            frac = 23'(quot & 64'h7FFFFF);
            e    = e - 1;
        end
        if (e >= 255) return {2'b00, s, 31'h7F800000};
        if (e <= 0)   return {2'b00, s, 31'h0};
        return {2'b00, s, 8'(e), frac};
    endfunction

    // One operation: launch at a falling edge, scramble inputs while busy, check timing and result.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [31:0] eq, input logic edz, input int elat,
                          input string tag);
        int lat;
        bit seen;
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0; seen = 0;
        while (!seen && lat < 40) begin
            a = $urandom; b = $urandom;
            @(negedge clk);
            lat++;
            if (done) seen = 1;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_q"},   q, eq);
        chk({tag, "_dz"},  32'(dz), 32'(edz));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(done), 32'd0);
        chk({tag, "_q_hold"}, q, eq);
        @(negedge clk);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        int          k;
        v = $urandom;
        k = int'($urandom_range(0, 19));
        case (k)
            0: v[30:0] = 31'h0;                          // zero
            1: v[30:0] = 31'h7F800000;                   // inf
            2: v[30:23] = 8'hFF;                         // NaN or inf
            3: v[30:23] = 8'h00;                         // denormal -> zero
            default: v[30:23] = 8'($urandom_range(1, 254));
        endcase
        return v;
    endfunction

    initial begin
        logic [33:0] r;
        logic [31:0] ra, rb;
        int          ndone, lat_seen;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q",    q,         32'd0);
        chk("rst_dz",   32'(dz),   32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26, "six_by_two");
        run_op(32'hC0A00000, 32'h40200000, 32'hC0000000, 1'b0, 26, "neg5_by_2p5");
        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26, "one_by_three");
        run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1,  "div_zero");
        run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1,  "zero_zero");
        run_op(32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 1,  "inf_by_two");
        run_op(32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1,  "inf_inf");
        run_op(32'h40000000, 32'hFF800000, 32'h80000000, 1'b0, 1,  "fin_by_ninf");
        run_op(32'h7FC12345, 32'h3F800000, 32'h7FC00000, 1'b0, 1,  "nan_a");
        run_op(32'h80400000, 32'h40000000, 32'h80000000, 1'b0, 1,  "denorm_a");
        run_op(32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 26, "overflow");
        run_op(32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 26, "underflow");

        // Second start while busy must be ignored.
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; lat_seen = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) begin a = 32'h3F800000; b = 32'h40400000; start = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
            if (done) begin ndone++; lat_seen = c; end
        end
        start = 1'b0;
        chk("ignore_ndone", 32'(ndone), 32'd1);
        chk("ignore_lat",   32'(lat_seen), 32'd26);
        chk("ignore_q",     q, 32'h40400000);

        // Reset in the middle of DIV aborts with no done pulse.
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 12; c++) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_q",    q,         32'd0);
        chk("mid_rst_dz",   32'(dz),   32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26, "after_rst");

        // Randomized operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = rand_fp();
            rb = rand_fp();
            r  = ref_div(ra, rb);
            run_op(ra, rb, r[31:0], r[32], r[33] ? 1 : 26, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/divf_seq.md
DIVF_SEQ -- requirements
Module: divf_seq

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 start  input  1  request; sampled only in IDLE.
REQ-004 a  input  32  dividend, IEEE-754 single; sampled with start.
REQ-005 b  input  32  divisor, IEEE-754 single; sampled with start.
REQ-006 busy  output  1  high from the edge after start is accepted until done deasserts.
REQ-007 done  output  1  one-cycle pulse; q and dz valid while high.
REQ-008 q  output  32  quotient a/b, IEEE-754 single; held until next accepted start.
REQ-009 dz  output  1  divide-by-zero flag (finite nonzero a, zero b); held with q.

Function
REQ-010 States SHALL be IDLE, DIV, NORM, DONE.
REQ-011 IDLE: start=1 at edge N latches a, b, sign = a[31]^b[31], exp = ea-eb+127 (10-bit signed), mantissas with hidden 1; next state is DIV, or DONE for special operands.
REQ-012 DIV SHALL run restoring division, one quotient bit per cycle, for exactly 25 cycles (edges N+1..N+25), then go to NORM.
REQ-013 NORM (edge N+26) SHALL apply the following normalisation: if the quotient MSB=0, shift left 1 and decrement exp. It then truncates to 23 fraction bits (round toward zero), registers q and dz, and enters DONE with done=1.
REQ-014 Normal-path latency SHALL be 26 cycles: done is high between edges N+26 and N+27. Special-path latency SHALL be 1 cycle: done is high between edges N+1 and N+2.
REQ-015 DONE SHALL return to IDLE on the next edge. start is accepted again from that IDLE cycle onward.
REQ-016 start while busy or in DONE SHALL be ignored, and a/b changes then SHALL have no effect.
REQ-017 Inputs with exponent field 0 (zero or denormal) SHALL be treated as signed zero.
REQ-018 Special operands:
- NaN in either operand -> 0x7FC00000.
- 0/0 -> 0x7FC00000.
- inf/inf -> 0x7FC00000.
- inf/finite -> signed inf.
- finite/inf -> signed zero.
- 0/nonzero -> signed zero.
- nonzero finite/0 -> signed inf with dz=1.
dz SHALL be 0 in every other case.
REQ-019 Final exp >= 255 SHALL give signed inf (0x7F800000 | sign<<31). Final exp <= 0 SHALL give signed zero.
REQ-020 The divider SHALL NOT emit denormal results.

Reset
REQ-021 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, q=0x00000000, dz=0, and clear the iteration counter, independent of clk.
REQ-022 Reset during DIV or NORM SHALL abort the operation with no done pulse. The first start after rst_n rises SHALL behave as a fresh operation.

Structure
REQ-023 A shared fp32 package SHALL hold: field widths (1/8/23), bias 127, canonical NaN 0x7FC00000, inf 0x7F800000, the state encoding and the iteration count 25.
REQ-024 One sub-module divf_mant SHALL implement the 25-step restoring mantissa divider (load, step, quotient out). divf_seq SHALL own the FSM, the exponent/sign logic and the special-case decode.

Verification
REQ-025 a=0x40C00000 (6.0), b=0x40000000 (2.0), start 1 cycle -> done exactly 26 cycles later, q=0x40400000, dz=0.
REQ-026 a=0xC0A00000 (-5.0), b=0x40200000 (2.5) -> q=0xC0000000. Then a=0x3F800000 (1.0), b=0x40400000 (3.0) -> q=0x3EAAAAAA (truncation), exercising the normalise shift.
REQ-027 Special-case vectors, each with done 1 cycle after start:
- a=0x3F800000, b=0x00000000 -> q=0x7F800000, dz=1.
- a=0, b=0 -> q=0x7FC00000, dz=0.
- a=0x7F800000, b=0x40000000 -> q=0x7F800000, dz=0.
REQ-028 a=0x7F000000, b=0x00800000 -> q=0x7F800000 (overflow). a=0x00800000, b=0x7F000000 -> q=0x00000000 (underflow).
REQ-029 Start 6.0/2.0, pulse start again with a=1.0, b=3.0 at cycle 10 -> second start ignored, single done, q=0x40400000.
REQ-030 Assert rst_n=0 mid-DIV at cycle 12 -> outputs zero immediately, no done. A subsequent 6.0/2.0 gives q=0x40400000 after 26 cycles.
